// File: rtl/int_generator.sv
// rtl/int_generator.sv - scheduled interrupt source with write-acknowledge, overrun flag and assertion count
module int_generator #(
    parameter logic [31:0] INT_ADDR    = 32'h0000_7F20,
    parameter int unsigned FIRST_DELAY = 100,
    parameter int unsigned PERIOD      = 200,
    parameter int unsigned MAX_IRQ     = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_int_addr,
    input  logic [3:0]  m_int_byteen,
    output logic        interrupt,
    output logic [15:0] irq_count,
    output logic        overrun
);

    localparam logic [31:0] FIRST_LOAD  = 32'(FIRST_DELAY - 1);
    localparam logic [31:0] PERIOD_LOAD = 32'(PERIOD - 1);

    typedef enum logic [1:0] {
        S_WAIT,
        S_ASSERT,
        S_DONE
    } state_t;

    state_t      state, state_next;
    logic [31:0] cnt, cnt_next;
    logic [31:0] pend, pend_next;
    logic        interrupt_next;
    logic [15:0] irq_count_next;
    logic        overrun_next;
    logic        ack;
    logic        limit_hit;

    // Byte-lane bits of the address are ignored; any enabled byte counts as a write.
    assign ack       = (m_int_addr[31:2] == INT_ADDR[31:2]) && (|m_int_byteen);
    assign limit_hit = (MAX_IRQ != 0) && ({16'd0, irq_count} >= MAX_IRQ);

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        pend_next      = pend;
        interrupt_next = interrupt;
        irq_count_next = irq_count;
        overrun_next   = overrun;
        case (state)
            S_WAIT: begin
                if (cnt == 32'd0) begin
                    state_next     = S_ASSERT;
                    interrupt_next = 1'b1;
                    pend_next      = 32'd0;
                    if (irq_count != 16'hFFFF)
                        irq_count_next = irq_count + 16'd1;
                end else begin
                    cnt_next = cnt - 32'd1;
                end
            end
            S_ASSERT: begin
                // Acknowledge takes priority over the overrun threshold in the same cycle.
                if (ack) begin
                    interrupt_next = 1'b0;
                    pend_next      = 32'd0;
                    cnt_next       = PERIOD_LOAD;
                    state_next     = limit_hit ? S_DONE : S_WAIT;
                end else if (pend == PERIOD_LOAD) begin
                    overrun_next = 1'b1;
                end else begin
                    pend_next = pend + 32'd1;
                end
            end
            S_DONE: begin
                interrupt_next = 1'b0;
            end
            default: begin
                state_next = S_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_WAIT;
            cnt       <= FIRST_LOAD;
            pend      <= 32'd0;
            interrupt <= 1'b0;
            irq_count <= 16'd0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            pend      <= pend_next;
            interrupt <= interrupt_next;
            irq_count <= irq_count_next;
            overrun   <= overrun_next;
        end
    end

endmodule

// File: doc/int_generator.md
# int_generator

Interrupt source at the far end of the processor's interrupt-generator port. It raises the external `interrupt` line on a fixed schedule, holds it until the processor acknowledges by writing to the generator's address, then re-arms. It sits beside the two timers on the system side of the bridge: it consumes the bridge's `int_addr`/`int_byteen` and drives the `interrupt` input of the `mips` top (HWInt[2]). It also supplies self-checking status for the bench.

## Interface
- `INT_ADDR`, 32'h0000_7F20, acknowledge address; compared on bits [31:2] only.
- `FIRST_DELAY`, 100, cycles from reset release to the first assertion; must be ≥ 1.
- `PERIOD`, 200, cycles from an acknowledge to the next assertion; also the overrun threshold; must be ≥ 1.
- `MAX_IRQ`, 0, number of assertions before going permanently quiet; 0 means unlimited.

Ports:
- `clk` input 1: system clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `m_int_addr` input 32: write address from the bridge.
- `m_int_byteen` input 4: byte enables from the bridge; any nonzero value marks a write.
- `interrupt` output 1: registered interrupt request to the processor.
- `irq_count` output 16: number of assertions since reset; saturates at 16'hFFFF.
- `overrun` output 1: sticky flag; the request stayed pending for `PERIOD` cycles without an acknowledge.

## Operation
- An acknowledge (`ack`) is `m_int_addr[31:2] == INT_ADDR[31:2]` && `|m_int_byteen`. Data is not used.
- **States:**
  - WAIT: `cnt` decrements each cycle. When `cnt == 0`, the next state is ASSERT, `interrupt` goes to 1 and `irq_count` increments.
  - ASSERT: `interrupt` = 1 and `pend` counts up.
    - When `pend` reaches `PERIOD-1`, `overrun` sets and `pend` saturates. `interrupt` stays high.
    - On `ack`: `interrupt` goes to 0, `pend` clears and `cnt` loads `PERIOD-1`. The next state is DONE if `MAX_IRQ != 0` and `irq_count >= MAX_IRQ`; otherwise it is WAIT.
  - DONE: `interrupt` = 0 permanently. `ack` is ignored. Only `reset` leaves this state.
- An `ack` in WAIT or DONE has no effect: no counter change and no flag.
- In WAIT, an `ack` in the same cycle that `cnt` reaches 0 is ignored and the assertion proceeds.
- In ASSERT, if `ack` arrives in the same cycle `pend` would reach threshold, `ack` wins and `overrun` does not set.
- `cnt` and `pend` are 32 bits wide; `PERIOD-1` and `FIRST_DELAY-1` are computed at elaboration.
- `irq_count` never wraps.

## Timing
- Reset values: `interrupt` = 0, `irq_count` = 0, `overrun` = 0, state = WAIT, `cnt` = `FIRST_DELAY-1`, `pend` = 0.
- Reset has priority over every event, including mid-ASSERT. Outputs return to their reset values at the edge that samples `reset` = 1.
- Edge E0 is the last edge sampling `reset` = 1. `interrupt` rises at E0+`FIRST_DELAY`.
- `ack` sampled at edge Ea: `interrupt` is 0 after Ea and rises again at Ea+`PERIOD`.
- Minimum low time between assertions is `PERIOD` cycles. Acknowledge-to-deassert latency is 1 edge.
- `interrupt` rises at Er. With no `ack`, `overrun` rises at Er+`PERIOD`.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **First assertion and acknowledge.** Defaults; release reset at E0 → `interrupt` = 0 through E0+99, and 1 at E0+100 with `irq_count` = 1. Write 0x7F20 with byteen 4'b1111 at E0+110 → `interrupt` = 0 after E0+110 and 1 again at E0+310 with `irq_count` = 2.
- **Non-acknowledges.** While asserted, write 0x7F24 with byteen 4'b1111, then 0x7F20 with byteen 4'b0000, then 0x7F23 with byteen 4'b0001:
  - first two → `interrupt` stays 1 and `irq_count` is unchanged;
  - third → acknowledges, because bits [1:0] are ignored.
- **Overrun.** Defaults, no `ack` after the first assertion at E0+100 → `overrun` = 1 at E0+300 and `interrupt` still 1. A later `ack` clears `interrupt` but `overrun` stays 1.
- **Limit reached.** `MAX_IRQ` = 2, `PERIOD` = 10, each assertion acknowledged 3 cycles after it rises → exactly two pulses, then `interrupt` = 0 for 1000 further cycles. Further acks are ignored and `irq_count` = 2.
- **Reset mid-operation.** Assert `reset` for 1 cycle while `interrupt` = 1 and `overrun` = 1 → all outputs are 0 after that edge. The next assertion occurs `FIRST_DELAY` edges later.
- **Early acknowledge.** `ack` in WAIT at E0+50 → no effect; the first assertion still occurs at E0+100.
